// File: rtl/alu_issue_stage.sv
// Execute-stage issuer/collector: decodes ALU control into an EX register that drives the
// external combinational ALU, then captures its result into an EX/MEM register.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_alu_op,
  input  logic [2:0]               in_funct3,
  input  logic                     in_funct7b5,
  input  logic                     in_is_rtype,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [REG_ADDR_W-1:0]    in_rd,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_result,
  output logic [REG_ADDR_W-1:0]    out_rd,
  output logic                     out_is_branch,
  output logic                     out_branch_taken
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_NE   = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_GE   = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_LT   = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ   = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_NONE = '1;

  // S1 (EX) registers
  logic                     v1_q, v1_d;
  logic [DATA_WIDTH-1:0]    srca_q, srca_d;
  logic [DATA_WIDTH-1:0]    srcb_q, srcb_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [REG_ADDR_W-1:0]    rd1_q, rd1_d;
  logic                     br1_q, br1_d;
  // S2 (EX/MEM) registers
  logic                     v2_q, v2_d;
  logic [DATA_WIDTH-1:0]    res_q, res_d;
  logic [REG_ADDR_W-1:0]    rd2_q, rd2_d;
  logic                     br2_q, br2_d;

  logic                     adv1, adv2, s2_free, accept;
  logic [OPCODE_LENGTH-1:0] dec_op;
  logic [DATA_WIDTH-1:0]    dec_srcb;
  logic                     dec_br;

  assign adv2     = v2_q & out_ready;
  assign s2_free  = ~v2_q | out_ready;
  assign adv1     = v1_q & s2_free;
  assign in_ready = ~v1_q | s2_free;
  assign accept   = in_valid & in_ready;

  always_comb begin
    dec_op   = OP_NONE;
    dec_srcb = in_imm;
    dec_br   = 1'b0;
    case (in_alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        dec_br   = 1'b1;
        dec_srcb = in_rs2_data;
        case (in_funct3)
          3'b000:  dec_op = OP_EQ;
          3'b001:  dec_op = OP_NE;
          3'b100:  dec_op = OP_LT;
          3'b101:  dec_op = OP_GE;
          default: dec_op = OP_NONE;
        endcase
      end
      2'b10: begin
        dec_srcb = in_is_rtype ? in_rs2_data : in_imm;
        case (in_funct3)
          3'b000:  dec_op = (in_is_rtype & in_funct7b5) ? OP_SUB : OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b100:  dec_op = OP_XOR;
          default: dec_op = OP_NONE;
        endcase
      end
      default: dec_op = OP_NONE;
    endcase
  end

  always_comb begin
    v1_d   = v1_q;
    srca_d = srca_q;
    srcb_d = srcb_q;
    op_d   = op_q;
    rd1_d  = rd1_q;
    br1_d  = br1_q;
    v2_d   = v2_q;
    res_d  = res_q;
    rd2_d  = rd2_q;
    br2_d  = br2_q;
    if (flush) begin
      // flush overrides both accept and advance; data regs keep stale values
      v1_d = 1'b0;
      v2_d = 1'b0;
      op_d = OP_NONE;
    end else begin
      if (accept) begin
        v1_d   = 1'b1;
        srca_d = in_rs1_data;
        srcb_d = dec_srcb;
        op_d   = dec_op;
        rd1_d  = in_rd;
        br1_d  = dec_br;
      end else if (adv1) begin
        v1_d = 1'b0;
      end
      if (adv1) begin
        v2_d  = 1'b1;
        res_d = alu_result;
        rd2_d = rd1_q;
        br2_d = br1_q;
      end else if (adv2) begin
        v2_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      srca_q <= '0;
      srcb_q <= '0;
      op_q   <= OP_NONE;
      rd1_q  <= '0;
      br1_q  <= 1'b0;
      v2_q   <= 1'b0;
      res_q  <= '0;
      rd2_q  <= '0;
      br2_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      srca_q <= srca_d;
      srcb_q <= srcb_d;
      op_q   <= op_d;
      rd1_q  <= rd1_d;
      br1_q  <= br1_d;
      v2_q   <= v2_d;
      res_q  <= res_d;
      rd2_q  <= rd2_d;
      br2_q  <= br2_d;
    end
  end

  assign alu_srca         = srca_q;
  assign alu_srcb         = srcb_q;
  assign alu_operation    = op_q;
  assign out_valid        = v2_q;
  assign out_result       = res_q;
  assign out_rd           = rd2_q;
  assign out_is_branch    = br2_q;
  assign out_branch_taken = br2_q & res_q[0];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: drives the stage with a behavioural ALU and checks its output
// stream against an instruction-level model with an in-order expectation queue.
module tb_alu_issue_stage;
  localparam int DW = 32;
  localparam int OL = 4;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [1:0]    in_alu_op;
  logic [2:0]    in_funct3;
  logic          in_funct7b5, in_is_rtype;
  logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] alu_srca, alu_srcb, alu_result;
  logic [OL-1:0] alu_operation;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_rd;
  logic          out_is_branch, out_branch_taken;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] res;
    logic [RW-1:0] rd;
    logic          br;
    bit            entered;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_W(RW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_is_rtype(in_is_rtype), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rd(in_rd),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_operation(alu_operation),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_is_branch(out_is_branch), .out_branch_taken(out_branch_taken)
  );

  // Behavioural ALU the stage drives
  always_comb begin
    alu_result = '0;
    case (alu_operation)
      4'b0000: alu_result = alu_srca & alu_srcb;
      4'b0001: alu_result = alu_srca - alu_srcb;
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0011: alu_result = DW'(alu_srca != alu_srcb);
      4'b0100: alu_result = alu_srca | alu_srcb;
      4'b0101: alu_result = alu_srca ^ alu_srcb;
      4'b0110: alu_result = DW'($signed(alu_srca) >= $signed(alu_srcb));
      4'b0111: alu_result = DW'($signed(alu_srca) < $signed(alu_srcb));
      4'b1000: alu_result = DW'(alu_srca == alu_srcb);
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level meaning of the offered op
  function automatic exp_t ref_op();
    exp_t          e;
    logic [DW-1:0] a, b;
    a = in_rs1_data;
    b = in_is_rtype ? in_rs2_data : in_imm;
    e.rd = in_rd;
    e.br = (in_alu_op == 2'd1);
    e.entered = 1'b0;
    e.res = '0;
    if (in_alu_op == 2'd0) e.res = a + in_imm;
    else if (in_alu_op == 2'd1) begin
      if (in_funct3 == 3'd0)      e.res = DW'(a == in_rs2_data);
      else if (in_funct3 == 3'd1) e.res = DW'(a != in_rs2_data);
      else if (in_funct3 == 3'd4) e.res = DW'($signed(a) < $signed(in_rs2_data));
      else if (in_funct3 == 3'd5) e.res = DW'($signed(a) >= $signed(in_rs2_data));
    end else if (in_alu_op == 2'd2) begin
      if (in_funct3 == 3'd0)      e.res = (in_is_rtype && in_funct7b5) ? a - b : a + b;
      else if (in_funct3 == 3'd7) e.res = a & b;
      else if (in_funct3 == 3'd6) e.res = a | b;
      else if (in_funct3 == 3'd4) e.res = a ^ b;
    end
    return e;
  endfunction

  task automatic set_op(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                        input logic f7, input logic rt, input logic [DW-1:0] r1,
                        input logic [DW-1:0] r2, input logic [DW-1:0] im, input logic [RW-1:0] rd);
    in_valid = v; in_alu_op = aop; in_funct3 = f3; in_funct7b5 = f7; in_is_rtype = rt;
    in_rs1_data = r1; in_rs2_data = r2; in_imm = im; in_rd = rd;
  endtask

  task automatic rand_op();
    logic [DW-1:0] r1;
    logic [2:0]    f3;
    r1 = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom);
    f3 = 3'($urandom);
    if (in_alu_op == 2'd1 && $urandom_range(0, 4) != 0) f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4;
    set_op($urandom_range(0, 3) != 0, 2'($urandom), f3, 1'($urandom), 1'($urandom), r1,
           ($urandom_range(0, 2) == 0) ? r1 : DW'($urandom), DW'($urandom), RW'($urandom));
    if (in_alu_op == 2'd1 && $urandom_range(0, 2) != 0) in_funct3 = {1'($urandom), 1'b0, 1'($urandom)};
  endtask

  // One clock: check outputs against the model, then advance the model over the edge.
  task automatic cycle(output bit accepted);
    bit   vexp, pop;
    exp_t e;
    #1;
    vexp = (q.size() > 0) && q[0].entered;
    chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    chk("out_valid", out_valid, vexp);
    if (vexp) begin
      chk("out_result", out_result, q[0].res);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_is_branch", out_is_branch, q[0].br);
      chk("out_branch_taken", out_branch_taken, q[0].br & q[0].res[0]);
    end
    accepted = in_valid && (q.size() < 2 || out_ready) && !flush;
    pop = vexp && out_ready;
    e = ref_op();
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      foreach (q[i]) q[i].entered = 1'b1;
      if (accepted) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  bit acc;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_op(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_operation", alu_operation, 4'hF);
    chk("rst_alu_srca", alu_srca, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // ADD R-type
    set_op(1'b1, 2'd2, 3'd0, 1'b0, 1'b1, 32'd5, 32'd7, 32'd100, 5'd3);
    cycle(acc);
    in_valid = 1'b0;
    #1;
    chk("add_operation", alu_operation, 4'b0010);
    chk("add_srca", alu_srca, 32'd5);
    chk("add_srcb", alu_srcb, 32'd7);
    idle(3);

    // SUB then I-type with f7b5 set (must stay ADD, srcb from imm)
    set_op(1'b1, 2'd2, 3'd0, 1'b1, 1'b1, 32'd3, 32'd8, 32'd0, 5'd4);
    cycle(acc);
    set_op(1'b1, 2'd2, 3'd0, 1'b1, 1'b0, 32'd1, 32'd99, 32'd4, 5'd5);
    cycle(acc);
    idle(3);

    // Branches
    set_op(1'b1, 2'd1, 3'd1, 1'b0, 1'b1, 32'd9, 32'd9, 32'd0, 5'd6);
    cycle(acc);
    set_op(1'b1, 2'd1, 3'd0, 1'b0, 1'b1, 32'd9, 32'd9, 32'd0, 5'd7);
    cycle(acc);
    #1 chk("beq_operation", alu_operation, 4'b1000);
    set_op(1'b1, 2'd1, 3'd4, 1'b0, 1'b1, 32'd2, 32'd3, 32'd0, 5'd8);
    cycle(acc);
    idle(3);

    // Backpressure: back-to-back with out_ready low for 3 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 2'd0, 3'd0, 1'b0, 1'b0, DW'(i * 10), 32'd0, 32'd1, RW'(10 + i));
      cycle(acc);
    end
    #1 chk("stall_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 3; i < 5; i++) begin
      set_op(1'b1, 2'd0, 3'd0, 1'b0, 1'b0, DW'(i * 10), 32'd0, 32'd1, RW'(10 + i));
      cycle(acc);
    end
    idle(4);

    // Randomized traffic; an op is held until accepted unless flushed
    rand_op();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 29) == 0);
      cycle(acc);
      if (acc || flush || !in_valid) rand_op();
    end
    flush = 1'b0;
    idle(4);

    // Flush with both stages full and a new op offered
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_op(1'b1, 2'd2, 3'd6, 1'b0, 1'b1, 32'h0F, DW'(i), 32'd0, RW'(20 + i));
      cycle(acc);
    end
    set_op(1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1, 5'd30);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 chk("flush_out_valid", out_valid, 1'b0);
    idle(3);

    // Async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 2'd2, 3'd7, 1'b0, 1'b1, 32'hFF, DW'(i + 1), 32'd0, RW'(i));
      cycle(acc);
    end
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_alu_operation", alu_operation, 4'hF);
    chk("arst_out_result", out_result, 32'd0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
